// File: rtl/exe_div.sv
// exe_div: multi-cycle 32-bit DIV/DIVU unit for the EXE stage.
// Restoring shift-subtract divider, one quotient bit per clock.
// Result layout: {remainder -> HI, quotient -> LO}.
// Optional feature: define DIV_EARLY_OUT_EN to finish immediately when the
// dividend magnitude is below the divisor magnitude.
module exe_div (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        signed_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o,
  output logic        stall_req_o
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_DIVZERO = 2'd1,
    S_ON      = 2'd2,
    S_END     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;

  logic [5:0]  r_cnt;
  logic [64:0] r_work;
  logic [31:0] r_divisor;
  logic        r_signed;
  logic        r_sign1;
  logic        r_sign2;
  logic [63:0] r_result;

  logic        w_accept;
  logic        w_divZero;
  logic        w_earlyOut;
  logic [31:0] w_mag1;
  logic [31:0] w_mag2;
  logic [32:0] w_remShift;
  logic        w_fits;
  logic [32:0] w_diff;
  logic [64:0] w_step;
  logic        w_negQuot;
  logic        w_negRem;
  logic [31:0] w_quotFinal;
  logic [31:0] w_remFinal;
  logic        w_inEnd;

  // Operand magnitudes: signed mode divides absolute values and fixes signs at the end.
  assign w_mag1    = (signed_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
  assign w_mag2    = (signed_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
  assign w_accept  = start_i & ~annul_i;
  assign w_divZero = (opdata2_i == 32'd0);

`ifdef DIV_EARLY_OUT_EN
  assign w_earlyOut = (w_mag1 < w_mag2);
`else
  assign w_earlyOut = 1'b0;
`endif

  // One restoring step: shift left, subtract divisor if it fits, shift in the quotient bit.
  // The top working bit is always zero because the partial remainder stays below the divisor.
  assign w_remShift = r_work[63:31];
  assign w_fits     = r_work[64] | (w_remShift >= {1'b0, r_divisor});
  assign w_diff     = w_remShift - {1'b0, r_divisor};
  assign w_step     = w_fits ? {w_diff, r_work[30:0], 1'b1}
                             : {w_remShift, r_work[30:0], 1'b0};

  // Sign correction applied when the last step is stored.
  assign w_negQuot   = r_signed & (r_sign1 ^ r_sign2);
  assign w_negRem    = r_signed & r_sign1;
  assign w_quotFinal = w_negQuot ? (~w_step[31:0] + 32'd1) : w_step[31:0];
  assign w_remFinal  = w_negRem  ? (~w_step[63:32] + 32'd1) : w_step[63:32];

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Next-state logic; annul wins over start in every busy state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_divZero)       w_next = S_DIVZERO;
          else if (w_earlyOut) w_next = S_END;
          else                 w_next = S_ON;
        end
      end
      S_DIVZERO: w_next = annul_i ? S_IDLE : S_END;
      S_ON: begin
        if (annul_i)               w_next = S_IDLE;
        else if (r_cnt == 6'd31)   w_next = S_END;
      end
      S_END: begin
        if (annul_i || !start_i)   w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath registers: operand capture, iteration, and final result storage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 6'd0;
      r_work    <= 65'd0;
      r_divisor <= 32'd0;
      r_signed  <= 1'b0;
      r_sign1   <= 1'b0;
      r_sign2   <= 1'b0;
      r_result  <= 64'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt     <= 6'd0;
            r_work    <= {33'd0, w_mag1};
            r_divisor <= w_mag2;
            r_signed  <= signed_i;
            r_sign1   <= opdata1_i[31];
            r_sign2   <= opdata2_i[31];
            r_result  <= (!w_divZero && w_earlyOut) ? {opdata1_i, 32'd0} : 64'd0;
          end
        end
        S_DIVZERO: r_result <= 64'd0;
        S_ON: begin
          if (!annul_i) begin
            r_work <= w_step;
            r_cnt  <= r_cnt + 6'd1;
            if (r_cnt == 6'd31) r_result <= {w_remFinal, w_quotFinal};
          end
        end
        S_END: begin
          if (annul_i || !start_i) r_result <= 64'd0;
        end
        default: r_result <= 64'd0;
      endcase
    end
  end

  assign w_inEnd = (r_state == S_END);

  // Outputs: result only visible in END; stall while a request is pending.
  always_comb begin
    ready_o     = w_inEnd;
    result_o    = w_inEnd ? r_result : 64'd0;
    stall_req_o = start_i & ~w_inEnd & ~annul_i;
  end

endmodule
